frame_bank_scheduler: RTL

Triple-buffer bank scheduler between Input_Logic (frame writer) and Output_Logic (frame reader) around Matrix_Buffer. Assigns Matrix_Buffer banks so the writer never blocks and the reader always gets the newest complete frame. Limits output frame rate to one start per `MIN_FRAME_CYCLES`, counts dropped frames, and issues the per-frame start pulse that drives Output_Logic's image sequencing.

---
 rtl/frame_sched_pkg.sv | 16 +
 rtl/frame_period_timer.sv | 39 +++
 rtl/frame_bank_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
`default_nettype none
// Shared types for the triple-buffer frame bank scheduler.
package frame_sched_pkg;

  typedef logic [1:0] bank_t;

  localparam int NUM_BANKS = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_READ  = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_period_timer.sv
`default_nettype none
// Saturating frame-period timer: reports when MIN_FRAME_CYCLES have passed since the last clear.
module frame_period_timer #(
  parameter int MIN_FRAME_CYCLES = 1237500
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_clear,
  output logic O_elapsed
);

  localparam int TW = (MIN_FRAME_CYCLES > 0) ? $clog2(MIN_FRAME_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(MIN_FRAME_CYCLES);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (I_clear) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + TW'(1);
    end
  end

  // Reset to the limit so the very first frame is not held back.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      count_q <= LIMIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign O_elapsed = (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// Triple-buffer bank scheduler: the writer never blocks, the reader always gets the newest
// complete frame, read starts are rate limited and overwritten unread frames are counted.
module frame_bank_scheduler
  import frame_sched_pkg::*;
#(
  parameter int MAX_WIDTH        = 1920,
  parameter int MAX_HEIGHT       = 1080,
  parameter int MIN_FRAME_CYCLES = 1237500,
  parameter int DROP_CNT_WIDTH   = 16,
  localparam int WW = $clog2(MAX_WIDTH),
  localparam int HW = $clog2(MAX_HEIGHT)
) (
  input  logic                      I_clk,
  input  logic                      I_rst_n,
  input  logic                      I_enable,
  input  logic                      I_wr_frame_done,
  input  logic [WW-1:0]             I_image_width,
  input  logic [HW-1:0]             I_image_height,
  output logic [1:0]                O_wr_bank,
  output logic                      O_rd_start,
  output logic [1:0]                O_rd_bank,
  output logic [WW-1:0]             O_rd_width,
  output logic [HW-1:0]             O_rd_height,
  input  logic                      I_rd_done,
  output logic                      O_busy,
  output logic [DROP_CNT_WIDTH-1:0] O_frames_dropped
);

  sched_state_t              state_q, state_d;
  bank_t                     wr_bank_q, wr_bank_d;
  bank_t                     ready_bank_q, ready_bank_d;
  bank_t                     rd_bank_q, rd_bank_d;
  logic                      ready_valid_q, ready_valid_d;
  logic [WW-1:0]             ready_w_q, ready_w_d;
  logic [HW-1:0]             ready_h_q, ready_h_d;
  logic [WW-1:0]             rd_w_q, rd_w_d;
  logic [HW-1:0]             rd_h_q, rd_h_d;
  logic                      rd_start_q, rd_start_d;
  logic                      busy_q, busy_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic period_elapsed;
  logic wr_done_valid;
  logic go;

  assign wr_done_valid = I_wr_frame_done && (I_image_width != '0) && (I_image_height != '0);
  assign go            = (state_q == S_IDLE) && I_enable && ready_valid_q && period_elapsed;

  frame_period_timer #(
    .MIN_FRAME_CYCLES(MIN_FRAME_CYCLES)
  ) u_period_timer (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_clear   (go),
    .O_elapsed (period_elapsed)
  );

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    ready_bank_d  = ready_bank_q;
    rd_bank_d     = rd_bank_q;
    ready_valid_d = ready_valid_q;
    ready_w_d     = ready_w_q;
    ready_h_d     = ready_h_q;
    rd_w_d        = rd_w_q;
    rd_h_d        = rd_h_q;
    drop_d        = drop_q;

    case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: state_d = S_READ;
      S_READ:  if (I_rd_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_start_d = go;
    busy_d     = (state_d != S_IDLE);

    if (go) begin
      rd_bank_d = ready_bank_q;
      rd_w_d    = ready_w_q;
      rd_h_d    = ready_h_q;
    end

    if (wr_done_valid) begin
      ready_w_d = I_image_width;
      ready_h_d = I_image_height;
    end

    // A simultaneous start and write rotates all three roles; the fresh frame stays pending.
    if (go && wr_done_valid) begin
      ready_bank_d  = wr_bank_q;
      wr_bank_d     = rd_bank_q;
      ready_valid_d = 1'b1;
    end else if (go) begin
      ready_bank_d  = rd_bank_q;
      ready_valid_d = 1'b0;
    end else if (wr_done_valid) begin
      ready_bank_d  = wr_bank_q;
      wr_bank_d     = ready_bank_q;
      ready_valid_d = 1'b1;
      if (ready_valid_q && (drop_q != '1)) begin
        drop_d = drop_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 2'd0;
      ready_bank_q  <= 2'd1;
      rd_bank_q     <= 2'd2;
      ready_valid_q <= 1'b0;
      ready_w_q     <= '0;
      ready_h_q     <= '0;
      rd_w_q        <= '0;
      rd_h_q        <= '0;
      rd_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      ready_bank_q  <= ready_bank_d;
      rd_bank_q     <= rd_bank_d;
      ready_valid_q <= ready_valid_d;
      ready_w_q     <= ready_w_d;
      ready_h_q     <= ready_h_d;
      rd_w_q        <= rd_w_d;
      rd_h_q        <= rd_h_d;
      rd_start_q    <= rd_start_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
    end
  end

  assign O_wr_bank        = wr_bank_q;
  assign O_rd_bank        = rd_bank_q;
  assign O_rd_width       = rd_w_q;
  assign O_rd_height      = rd_h_q;
  assign O_rd_start       = rd_start_q;
  assign O_busy           = busy_q;
  assign O_frames_dropped = drop_q;

endmodule
`default_nettype wire
